irq_scheduler: RTL and testbench
================================

Name: irq_scheduler

Overview:
- Prioritised, nesting interrupt scheduler for the 16-bit single-cycle core.
- Collects NUM_SRC external interrupt lines and software triggers into pending flags, masks them with per-source enables, and picks the highest-priority eligible source.
- Drives the PC override (enable/addr_out) with the source's vector on entry, and with the saved return address on routine end.
- Holds a return-address/priority stack so higher-priority sources can preempt a running routine.

Parameters:
NUM_SRC, 4, number of interrupt sources; index 0 is the highest priority
ADDR_W, 16, PC width
STACK_DEPTH, 4, maximum nesting depth
VEC_BASE, 16'h0100, vector address of source 0
VEC_STRIDE, 16'h0010, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE, truncated to ADDR_W

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
irq_src  in  NUM_SRC  asynchronous external request lines, rising-edge triggered
cfg_idx  in  $clog2(NUM_SRC)  source index used by the four flag commands
ier_set_flag  in  1  set IER[cfg_idx]
ier_unset_flag  in  1  clear IER[cfg_idx]
ifr_set_flag  in  1  software trigger: set IFR[cfg_idx]
ifr_unset_flag  in  1  clear IFR[cfg_idx]
end_routine  in  1  routine-return instruction executing this cycle
rtrn_addr_in  in  ADDR_W  core's next-PC value (address to resume at)
enable  out  1  PC override select; one-cycle pulse
addr_out  out  ADDR_W  PC override value
ier_q  out  NUM_SRC  enable register
ifr_q  out  NUM_SRC  pending register
active_lvl  out  $clog2(NUM_SRC)+1  priority of the running routine; NUM_SRC = none
stack_full  out  1  depth == STACK_DEPTH
spurious_err  out  1  sticky; end_routine received with an empty stack

Behaviour:
- Reset (async): IER=0, IFR=0, sync/edge flops=0, stack empty, active_lvl=NUM_SRC, state=IDLE, enable=0, addr_out=0, spurious_err=0.
- Input path: irq_src goes through a 2-flop synchroniser plus a previous-value flop. A rising edge on synced bit i sets IFR[i] at the 3rd rising clk edge after irq_src[i] rises. Levels held high do not retrigger.
- Flag commands:
  - Take effect at the next edge.
  - ier_set and ier_unset for the same index in the same cycle: unset wins.
  - Any IFR set (hardware edge or ifr_set_flag) together with any IFR clear (ifr_unset_flag or entry clear) on the same bit: set wins; no event is lost.
- Eligibility: eligible[i] = IFR[i] & IER[i] & (i < active_lvl). Winner is the lowest eligible index.
- FSM states: IDLE (no routine), SERVICE (routine running), ENTER, RETURN.
- IDLE/SERVICE:
  - end_routine with stack non-empty -> RETURN. This takes precedence over any eligible source.
  - end_routine with stack empty -> set spurious_err, stay in the current state.
  - Otherwise, any eligible source and !stack_full -> ENTER; latch winner w.
  - stack_full blocks preemption; the source stays pending.
- ENTER (1 cycle):
  - enable=1, addr_out=vector(w).
  - At the exiting edge: push {rtrn_addr_in, active_lvl}, clear IFR[w], set active_lvl=w, go to SERVICE.
- RETURN (1 cycle):
  - enable=1, addr_out=top-of-stack address.
  - At the exiting edge: pop, restore active_lvl from the popped entry.
  - Next state is IDLE if the stack is now empty, else SERVICE.
- enable/addr_out are registered state decodes, with no combinational path from inputs. Outside ENTER/RETURN: enable=0, addr_out holds its last value.
- Entry latency: eligible at edge k -> enable high during cycle k+1 -> resumed vector fetch at edge k+2.
- Back-to-back: after ENTER or RETURN, eligibility is re-evaluated in the following cycle. Minimum spacing is one cycle in SERVICE/IDLE.
- end_routine arriving during ENTER/RETURN is ignored; the controller drives it only from routine code.
- Reset mid-ENTER/RETURN: the pulse drops immediately and the stack is discarded.

Test Plan:
1. Reset, ier_set idx 2, pulse irq_src[2], rtrn_addr_in=16'h0040 -> IFR[2]=1 after 3 edges; one-cycle enable with addr_out=16'h0120; IFR[2]=0, active_lvl=2.
2. From case 1, end_routine -> one-cycle enable with addr_out=16'h0040; active_lvl=4, state IDLE, stack empty.
3. Nesting: in service of source 2, trigger source 0 (IER[0]=1) -> enable with addr_out=16'h0100 and active_lvl=0. Trigger source 3 -> no entry, IFR[3] stays 1. Two end_routines return 2 then 4, then source 3 enters at 16'h0130.
4. IER[1]=0 with ifr_set_flag idx 1 -> IFR[1]=1, no entry. Then ier_set idx 1 -> entry at 16'h0110 two cycles later. Separately, ier_set+ier_unset on the same index in the same cycle -> IER bit 0.
5. STACK_DEPTH=4 with nested sources 3,2,1,0, then pulse ifr_set idx 0 -> stack_full=1, no fifth entry. end_routine with empty stack -> spurious_err=1, no enable.
6. Assert rst asynchronously during an ENTER cycle -> enable=0 immediately; IER, IFR, active_lvl=4 and stack_full=0 without waiting for a clock edge.

Source files
------------

// File: rtl/irq_scheduler_if.sv
// Bus bundle between the core and the interrupt scheduler.
// The core side drives requests and commands, the scheduler drives PC override and status.
interface irq_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = 16
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int LVL_W = $clog2(NUM_SRC) + 1;

    logic [NUM_SRC-1:0] irq_src;
    logic [IDX_W-1:0]   cfg_idx;
    logic               ier_set_flag;
    logic               ier_unset_flag;
    logic               ifr_set_flag;
    logic               ifr_unset_flag;
    logic               end_routine;
    logic [ADDR_W-1:0]  rtrn_addr_in;

    logic               enable;
    logic [ADDR_W-1:0]  addr_out;
    logic [NUM_SRC-1:0] ier_q;
    logic [NUM_SRC-1:0] ifr_q;
    logic [LVL_W-1:0]   active_lvl;
    logic               stack_full;
    logic               spurious_err;

    modport master (
        output irq_src, cfg_idx,
        output ier_set_flag, ier_unset_flag,
        output ifr_set_flag, ifr_unset_flag,
        output end_routine, rtrn_addr_in,
        input  enable, addr_out, ier_q, ifr_q,
        input  active_lvl, stack_full, spurious_err
    );

    modport slave (
        input  irq_src, cfg_idx,
        input  ier_set_flag, ier_unset_flag,
        input  ifr_set_flag, ifr_unset_flag,
        input  end_routine, rtrn_addr_in,
        output enable, addr_out, ier_q, ifr_q,
        output active_lvl, stack_full, spurious_err
    );
endinterface

// File: rtl/irq_scheduler.sv
// Prioritised nesting interrupt scheduler: pending/enable flags, winner pick,
// PC override pulses on entry and return, and a return-address/priority stack.
module irq_scheduler #(
    parameter int                NUM_SRC     = 4,
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE    = 16'h0100,
    parameter logic [ADDR_W-1:0] VEC_STRIDE  = 16'h0010
) (
    input logic           clk,
    input logic           rst,
    irq_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int LVL_W = $clog2(NUM_SRC) + 1;
    localparam int DEP_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVICE,
        S_ENTER,
        S_RETURN
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] ier_q, ier_d;
    logic [NUM_SRC-1:0] ifr_q, ifr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [LVL_W-1:0]   act_q, act_d;
    logic [DEP_W-1:0]   depth_q, depth_d;
    logic [ADDR_W-1:0]  stk_addr_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  stk_addr_d [STACK_DEPTH];
    logic [LVL_W-1:0]   stk_lvl_q [STACK_DEPTH];
    logic [LVL_W-1:0]   stk_lvl_d [STACK_DEPTH];
    logic               en_q, en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               spur_q, spur_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cfg_oh;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] entry_clr;
    logic [IDX_W-1:0]   win;
    logic               any_elig;
    logic               full;
    logic               empty;
    logic [PTR_W-1:0]   top_idx;
    logic [PTR_W-1:0]   push_idx;

    function automatic logic [ADDR_W-1:0] vec_addr(input logic [IDX_W-1:0] w);
        return VEC_BASE + ADDR_W'(w) * VEC_STRIDE;
    endfunction

    // Two-flop synchroniser plus previous-value flop for edge detection
    always_comb begin
        sync1_d = bus.irq_src;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
    end

    // Stack bookkeeping and eligibility / lowest-index winner pick
    always_comb begin
        cfg_oh   = NUM_SRC'(1) << bus.cfg_idx;
        full     = (depth_q == DEP_W'(STACK_DEPTH));
        empty    = (depth_q == '0);
        top_idx  = PTR_W'(depth_q - DEP_W'(1));
        push_idx = PTR_W'(depth_q);
        win      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = ifr_q[i] & ier_q[i] & (LVL_W'(i) < act_q);
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = IDX_W'(i);
            end
        end
        any_elig = |elig;
    end

    // Next state, stack push/pop and override pulse decode
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        act_d      = act_q;
        depth_d    = depth_q;
        stk_addr_d = stk_addr_q;
        stk_lvl_d  = stk_lvl_q;
        en_d       = 1'b0;
        addr_d     = addr_q;
        spur_d     = spur_q;
        entry_clr  = '0;
        unique case (state_q)
            S_IDLE, S_SERVICE: begin
                if (bus.end_routine) begin
                    if (!empty) begin
                        state_d = S_RETURN;
                        en_d    = 1'b1;
                        addr_d  = stk_addr_q[top_idx];
                    end else begin
                        spur_d = 1'b1;
                    end
                end else if (any_elig && !full) begin
                    state_d = S_ENTER;
                    win_d   = win;
                    en_d    = 1'b1;
                    addr_d  = vec_addr(win);
                end
            end
            S_ENTER: begin
                stk_addr_d[push_idx] = bus.rtrn_addr_in;
                stk_lvl_d[push_idx]  = act_q;
                depth_d              = depth_q + DEP_W'(1);
                act_d                = LVL_W'(win_q);
                entry_clr            = NUM_SRC'(1) << win_q;
                state_d              = S_SERVICE;
            end
            S_RETURN: begin
                act_d   = stk_lvl_q[top_idx];
                depth_d = depth_q - DEP_W'(1);
                state_d = (depth_q == DEP_W'(1)) ? S_IDLE : S_SERVICE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flag registers: unset wins for IER, set wins for IFR
    always_comb begin
        ier_d = ier_q;
        if (bus.ier_set_flag) begin
            ier_d[bus.cfg_idx] = 1'b1;
        end
        if (bus.ier_unset_flag) begin
            ier_d[bus.cfg_idx] = 1'b0;
        end
        ifr_d = (ifr_q & ~(entry_clr | (bus.ifr_unset_flag ? cfg_oh : '0)))
              | rise | (bus.ifr_set_flag ? cfg_oh : '0);
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ier_q   <= '0;
            ifr_q   <= '0;
            win_q   <= '0;
            act_q   <= LVL_W'(NUM_SRC);
            depth_q <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            spur_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_addr_q[i] <= '0;
                stk_lvl_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            ier_q      <= ier_d;
            ifr_q      <= ifr_d;
            win_q      <= win_d;
            act_q      <= act_d;
            depth_q    <= depth_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            spur_q     <= spur_d;
            stk_addr_q <= stk_addr_d;
            stk_lvl_q  <= stk_lvl_d;
        end
    end

    assign bus.enable       = en_q;
    assign bus.addr_out     = addr_q;
    assign bus.ier_q        = ier_q;
    assign bus.ifr_q        = ifr_q;
    assign bus.active_lvl   = act_q;
    assign bus.stack_full   = full;
    assign bus.spurious_err = spur_q;
endmodule

// File: tb/tb_irq_scheduler.sv
// Bench for irq_scheduler: cycle model built from the scheduling rules,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_irq_scheduler;
    localparam int          NUM_SRC     = 4;
    localparam int          ADDR_W      = 16;
    localparam int          STACK_DEPTH = 4;
    localparam logic [15:0] VEC_BASE    = 16'h0100;
    localparam logic [15:0] VEC_STRIDE  = 16'h0010;

    logic clk = 1'b0;
    logic rst;

    irq_scheduler_if #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W)) bus ();

    irq_scheduler #(
        .NUM_SRC(NUM_SRC),
        .ADDR_W(ADDR_W),
        .STACK_DEPTH(STACK_DEPTH),
        .VEC_BASE(VEC_BASE),
        .VEC_STRIDE(VEC_STRIDE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] addr;
        int          lvl;
    } frame_t;

    frame_t      stk[$];
    logic [3:0]  m_ier, m_ifr;
    int          m_act;
    bit          m_spur, m_en;
    logic [15:0] m_addr;
    int          m_pend;  // 0 none, 1 entry pulse, 2 return pulse
    int          m_w;
    logic [3:0]  hist [3];

    function automatic logic [15:0] vec(input int i);
        return VEC_BASE + 16'(i) * VEC_STRIDE;
    endfunction

    task automatic model_reset();
        stk.delete();
        m_ier  = '0;
        m_ifr  = '0;
        m_act  = NUM_SRC;
        m_spur = 0;
        m_en   = 0;
        m_addr = '0;
        m_pend = 0;
        m_w    = 0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endtask

    task automatic model_step();
        logic [3:0] setm, clrm, oh;
        frame_t     f;
        int         w;
        oh   = 4'(1) << bus.cfg_idx;
        // request seen high two edges ago, low three edges ago
        setm = (hist[1] & ~hist[2]) | (bus.ifr_set_flag ? oh : 4'b0);
        clrm = bus.ifr_unset_flag ? oh : 4'b0;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = bus.irq_src;
        if (m_pend == 1) begin
            stk.push_back('{addr: bus.rtrn_addr_in, lvl: m_act});
            m_act = m_w;
            clrm  = clrm | (4'(1) << m_w);
            m_pend = 0;
        end else if (m_pend == 2) begin
            f = stk.pop_back();
            m_act  = f.lvl;
            m_pend = 0;
        end else if (bus.end_routine) begin
            if (stk.size() > 0) begin
                m_pend = 2;
                m_addr = stk[$].addr;
            end else begin
                m_spur = 1;
            end
        end else begin
            w = -1;
            for (int i = NUM_SRC - 1; i >= 0; i--)
                if (m_ifr[i] && m_ier[i] && i < m_act) w = i;
            if (w >= 0 && stk.size() < STACK_DEPTH) begin
                m_pend = 1;
                m_w    = w;
                m_addr = vec(w);
            end
        end
        m_en = (m_pend != 0);
        if (bus.ier_set_flag)   m_ier[bus.cfg_idx] = 1'b1;
        if (bus.ier_unset_flag) m_ier[bus.cfg_idx] = 1'b0;
        m_ifr = (m_ifr & ~clrm) | setm;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("enable",       bus.enable,       m_en);
                chk("addr_out",     bus.addr_out,     m_addr);
                chk("ier_q",        bus.ier_q,        m_ier);
                chk("ifr_q",        bus.ifr_q,        m_ifr);
                chk("active_lvl",   bus.active_lvl,   m_act);
                chk("stack_full",   bus.stack_full,   stk.size() == STACK_DEPTH);
                chk("spurious_err", bus.spurious_err, m_spur);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic ier_set(input int i);
        bus.cfg_idx      = 2'(i);
        bus.ier_set_flag = 1'b1;
        tick();
        bus.ier_set_flag = 1'b0;
    endtask

    task automatic ifr_set(input int i);
        bus.cfg_idx      = 2'(i);
        bus.ifr_set_flag = 1'b1;
        tick();
        bus.ifr_set_flag = 1'b0;
    endtask

    task automatic ifr_unset(input int i);
        bus.cfg_idx        = 2'(i);
        bus.ifr_unset_flag = 1'b1;
        tick();
        bus.ifr_unset_flag = 1'b0;
    endtask

    task automatic end_rt();
        bus.end_routine = 1'b1;
        tick();
        bus.end_routine = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.irq_src        = '0;
        bus.cfg_idx        = '0;
        bus.ier_set_flag   = 1'b0;
        bus.ier_unset_flag = 1'b0;
        bus.ifr_set_flag   = 1'b0;
        bus.ifr_unset_flag = 1'b0;
        bus.end_routine    = 1'b0;
        bus.rtrn_addr_in   = '0;
        tick(2);
        chk("rst_enable", bus.enable, 0);
        chk("rst_addr",   bus.addr_out, 0);
        chk("rst_ier",    bus.ier_q, 0);
        chk("rst_ifr",    bus.ifr_q, 0);
        chk("rst_lvl",    bus.active_lvl, 4);
        chk("rst_full",   bus.stack_full, 0);
        chk("rst_spur",   bus.spurious_err, 0);
        rst = 1'b0;
        tick();

        // entry via external edge on source 2
        ier_set(2);
        bus.rtrn_addr_in = 16'h0040;
        bus.irq_src = 4'b0100;
        tick(3);
        bus.irq_src = 4'b0000;
        chk("c1_ifr_set", bus.ifr_q[2], 1);
        chk("c1_en_early", bus.enable, 0);
        tick();
        chk("c1_enable", bus.enable, 1);
        chk("c1_vec", bus.addr_out, 16'h0120);
        tick();
        chk("c1_pulse_len", bus.enable, 0);
        chk("c1_ifr_clr", bus.ifr_q[2], 0);
        chk("c1_lvl", bus.active_lvl, 2);

        // return to the saved address
        end_rt();
        chk("c2_enable", bus.enable, 1);
        chk("c2_ret", bus.addr_out, 16'h0040);
        tick();
        chk("c2_lvl", bus.active_lvl, 4);
        chk("c2_en_off", bus.enable, 0);

        // nesting: 2, preempted by 0; 3 waits
        ier_set(0);
        ier_set(3);
        bus.rtrn_addr_in = 16'h0050;
        ifr_set(2);
        tick();
        chk("c3_vec2", bus.addr_out, 16'h0120);
        tick();
        chk("c3_lvl2", bus.active_lvl, 2);
        bus.rtrn_addr_in = 16'h0200;
        ifr_set(0);
        tick();
        chk("c3_en0", bus.enable, 1);
        chk("c3_vec0", bus.addr_out, 16'h0100);
        tick();
        chk("c3_lvl0", bus.active_lvl, 0);
        ifr_set(3);
        tick();
        chk("c3_no_entry3", bus.enable, 0);
        chk("c3_ifr3", bus.ifr_q[3], 1);
        end_rt();
        chk("c3_ret0", bus.addr_out, 16'h0200);
        tick();
        chk("c3_back2", bus.active_lvl, 2);
        tick();
        chk("c3_still_blk", bus.enable, 0);
        end_rt();
        chk("c3_ret2", bus.addr_out, 16'h0050);
        tick();
        chk("c3_back4", bus.active_lvl, 4);
        tick();
        chk("c3_en3", bus.enable, 1);
        chk("c3_vec3", bus.addr_out, 16'h0130);
        tick();
        chk("c3_lvl3", bus.active_lvl, 3);
        end_rt();
        tick();
        chk("c3_idle", bus.active_lvl, 4);

        // masked pending, then enable releases it
        ifr_set(1);
        tick();
        chk("c4_ifr1", bus.ifr_q[1], 1);
        chk("c4_masked", bus.enable, 0);
        ier_set(1);
        tick();
        chk("c4_vec1", bus.addr_out, 16'h0110);
        chk("c4_en1", bus.enable, 1);
        tick();
        chk("c4_lvl1", bus.active_lvl, 1);
        end_rt();
        tick();
        bus.cfg_idx = 2'd3;
        bus.ier_set_flag = 1'b1;
        bus.ier_unset_flag = 1'b1;
        tick();
        bus.ier_set_flag = 1'b0;
        bus.ier_unset_flag = 1'b0;
        chk("c4_ier_unset_wins", bus.ier_q[3], 0);
        bus.ifr_set_flag = 1'b1;
        bus.ifr_unset_flag = 1'b1;
        tick();
        bus.ifr_set_flag = 1'b0;
        bus.ifr_unset_flag = 1'b0;
        chk("c4_ifr_set_wins", bus.ifr_q[3], 1);
        ifr_unset(3);
        chk("c4_ifr_cleared", bus.ifr_q[3], 0);

        // full nesting 3,2,1,0
        ier_set(1);
        ier_set(3);
        for (int s = 3; s >= 0; s--) begin
            bus.rtrn_addr_in = 16'h1000 + 16'(s);
            ifr_set(s);
            tick();
            chk("c5_nest_vec", bus.addr_out, vec(s));
            tick();
            chk("c5_nest_lvl", bus.active_lvl, s);
        end
        chk("c5_full", bus.stack_full, 1);
        ifr_set(0);
        tick();
        chk("c5_no_fifth", bus.enable, 0);
        chk("c5_ifr0", bus.ifr_q[0], 1);
        ifr_unset(0);
        for (int k = 0; k < 4; k++) begin
            end_rt();
            chk("c5_ret_en", bus.enable, 1);
            chk("c5_ret_addr", bus.addr_out, 16'h1000 + 16'(k));
            tick();
            chk("c5_ret_lvl", bus.active_lvl, k + 1);
        end
        chk("c5_not_full", bus.stack_full, 0);
        end_rt();
        chk("c5_spur_noen", bus.enable, 0);
        chk("c5_spur", bus.spurious_err, 1);
        tick();

        // async reset during an entry pulse
        ifr_set(2);
        tick();
        chk("c6_in_entry", bus.enable, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("c6_enable", bus.enable, 0);
        chk("c6_ier", bus.ier_q, 0);
        chk("c6_ifr", bus.ifr_q, 0);
        chk("c6_lvl", bus.active_lvl, 4);
        chk("c6_full", bus.stack_full, 0);
        chk("c6_spur", bus.spurious_err, 0);
        tick();
        rst = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
